// File: rtl/chnl_pkg.sv
// Shared types and constants for the channel-to-stream bridge: FSM encoding,
// default parameters, words-per-beat and saturating counter helpers.
package chnl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } chnl_state_t;

    localparam int DEF_PCI_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH     = 16;
    localparam int DEF_WDOG_CYCLES    = 1048576;
    localparam int WORD_BITS          = 32;

    function automatic logic [31:0] words_per_beat(input int data_width);
        return 32'(data_width / WORD_BITS);
    endfunction

    // Length counters pin at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/chnl_sync_fifo.sv
// Synchronous FIFO with a registered head word, flush, and full/empty flags.
// A word pushed into an empty FIFO is visible on head one cycle later.
module chnl_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             push_ok, pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = head_reg;

    // Head bypasses the array when the slot being written is the next one to read.
    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
        count_next  = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        head_next   = (push_ok && (wr_ptr_reg == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(push_ok);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

endmodule

// File: rtl/chnl_stream_bridge.sv
// Bridges a RIFFA-style RX/TX channel pair to a valid/ready core stream.
// Optional stall watchdog enabled by defining CHNL_WATCHDOG_EN.
module chnl_stream_bridge
    import chnl_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = DEF_PCI_DATA_WIDTH,
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH,
    parameter int WDOG_CYCLES      = DEF_WDOG_CYCLES
) (
    input  logic                        CLK,
    input  logic                        RST,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN,
    output logic                        CHNL_TX_CLK,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN,
    output logic [C_PCI_DATA_WIDTH-1:0] core_data_in,
    output logic                        core_valid_in,
    input  logic                        core_ready_in,
    input  logic [C_PCI_DATA_WIDTH-1:0] core_data_out,
    input  logic                        core_valid_out,
    output logic                        core_ready_out,
    output logic [31:0]                 core_num_words,
    output logic                        busy,
    output logic                        err_timeout
);

    localparam logic [31:0] BEAT_WORDS = words_per_beat(C_PCI_DATA_WIDTH);

    chnl_state_t                 state_reg, state_next;
    logic [31:0]                 len_reg, rcount_reg, tcount_reg, tcount_inc;
    logic [C_PCI_DATA_WIDTH-1:0] core_data_in_reg;
    logic                        core_valid_in_reg;
    logic                        rx_ren, rx_beat, tx_valid, tx_beat;
    logic                        fifo_push, fifo_flush, fifo_full, fifo_empty;
    logic [C_PCI_DATA_WIDTH-1:0] fifo_head;
    logic                        wdog_expired;
    logic                        unused_inputs;

    assign unused_inputs = ^{CHNL_RX_OFF, CHNL_RX_LAST, CHNL_TX_ACK};

    assign CHNL_RX_CLK        = CLK;
    assign CHNL_TX_CLK        = CLK;
    assign CHNL_RX_ACK        = (state_reg == ST_RECV);
    assign CHNL_RX_DATA_REN   = rx_ren;
    assign CHNL_TX            = (state_reg == ST_SEND);
    assign CHNL_TX_LAST       = 1'b1;
    assign CHNL_TX_LEN        = len_reg;
    assign CHNL_TX_OFF        = '0;
    assign CHNL_TX_DATA       = fifo_head;
    assign CHNL_TX_DATA_VALID = tx_valid;
    assign core_data_in       = core_data_in_reg;
    assign core_valid_in      = core_valid_in_reg;
    assign core_ready_out     = (state_reg != ST_IDLE) && !fifo_full;
    assign core_num_words     = len_reg;
    assign busy               = (state_reg != ST_IDLE);

    assign rx_beat    = rx_ren && CHNL_RX_DATA_VALID;
    assign tx_beat    = tx_valid && CHNL_TX_DATA_REN;
    assign fifo_push  = core_valid_out && core_ready_out;
    assign tcount_inc = sat_add32(tcount_reg, BEAT_WORDS);

    always_comb begin
        state_next = state_reg;
        rx_ren     = 1'b0;
        tx_valid   = 1'b0;
        fifo_flush = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (CHNL_RX && (CHNL_RX_LEN != '0)) state_next = ST_RECV;
            end
            ST_RECV: begin
                rx_ren = (rcount_reg < len_reg) && core_ready_in;
                if (rcount_reg >= len_reg) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!fifo_empty) state_next = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = !fifo_empty;
                if (tx_valid && CHNL_TX_DATA_REN && (tcount_inc >= len_reg)) begin
                    state_next = ST_IDLE;
                    fifo_flush = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A watchdog abort overrides whatever the FSM wanted to do.
        if (wdog_expired) begin
            state_next = ST_IDLE;
            fifo_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg         <= ST_IDLE;
            len_reg           <= '0;
            rcount_reg        <= '0;
            tcount_reg        <= '0;
            core_valid_in_reg <= 1'b0;
            core_data_in_reg  <= '0;
        end else begin
            state_reg         <= state_next;
            core_valid_in_reg <= rx_beat;
            if (rx_beat) core_data_in_reg <= CHNL_RX_DATA;
            if ((state_reg == ST_IDLE) && CHNL_RX) begin
                len_reg    <= CHNL_RX_LEN;
                rcount_reg <= '0;
                tcount_reg <= '0;
            end else begin
                if (rx_beat) rcount_reg <= sat_add32(rcount_reg, BEAT_WORDS);
                if (tx_beat) tcount_reg <= tcount_inc;
            end
        end
    end

    chnl_sync_fifo #(
        .WIDTH (C_PCI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push),
        .push_data (core_data_out),
        .pop       (tx_beat),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef CHNL_WATCHDOG_EN
    localparam logic [31:0] WDOG_LIMIT = 32'(WDOG_CYCLES - 1);

    logic [31:0] wdog_reg;
    logic        err_timeout_reg;

    assign wdog_expired = (state_reg != ST_IDLE) && (wdog_reg >= WDOG_LIMIT);
    assign err_timeout  = err_timeout_reg;

    // Any progress (beat or state change) restarts the stall count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wdog_reg        <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            if ((state_reg == ST_IDLE) || rx_beat || tx_beat || (state_next != state_reg)) begin
                wdog_reg <= '0;
            end else begin
                wdog_reg <= wdog_reg + 32'd1;
            end
            if (wdog_expired) begin
                err_timeout_reg <= 1'b1;
            end else if ((state_reg == ST_IDLE) && CHNL_RX) begin
                err_timeout_reg <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg   = (WDOG_CYCLES == 0);
    assign wdog_expired = 1'b0;
    assign err_timeout  = 1'b0;
`endif

endmodule
